usb_reg_bridge: RTL and testbench
=================================

USB_REG_BRIDGE -- requirements
Module: usb_reg_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 21, the external address bus width.
REQ-002 The block SHALL have parameter MEMORY_WIDTH, default 8, log2 of bytes per region; MEMORY_BYTES = 1<<MEMORY_WIDTH.
REQ-003 The block SHALL have parameter RDDLY_LEN, default 3, the bus-drive hold cycles after read release (range 1..15).
REQ-004 The block SHALL have parameter STATUS_ADDR, default 'h1FFFFF, the status register address (used only with USB_STATUS_REG_EN).
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk_usb, input, 1, sole clock, all logic rising-edge.
REQ-006 The block SHALL have the following reset port: reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have the following bus inputs: data_i, 8, bus write data; addr, ADDR_WIDTH, bus address; rd_n, 1, active-low read strobe; wr_n, 1, active-low write strobe.
REQ-008 The block SHALL have the following bus outputs: data_o, 8, read data; data_oe, 1, bus drive enable (top-level tristate).
REQ-009 The block SHALL have the following memory ports: memory_input, output, MEMORY_BYTES*8, input region image; memory_output, input, MEMORY_BYTES*8, output region image.
REQ-010 The block SHALL have the following handshake ports: wr_strobe, output, 1, one-cycle commit pulse; wr_addr, output, MEMORY_WIDTH, committed byte index; crypto_done, input, 1, done pulse.

Function
REQ-011 rd_n and wr_n SHALL pass through 2-flop synchronizers reset to 1; all decisions use the synchronized values (rd_s, wr_s).
REQ-012 The FSM SHALL have states IDLE, WRITE, READ, HOLD, BUSERR.
REQ-013 In IDLE: rd_s=0 with wr_s=0 -> BUSERR; wr_s=0 only -> WRITE; rd_s=0 only -> READ.
REQ-014 BUSERR SHALL perform no write or read and return to IDLE only when rd_s=1 and wr_s=1.
REQ-015 WRITE SHALL register addr and data_i every cycle while wr_s=0, and commit on the wr_s rising edge using the last registered values, then go to IDLE.
REQ-016 A commit with registered addr >= MEMORY_BYTES SHALL write memory_input[(addr & (MEMORY_BYTES-1))*8 +: 8] and pulse wr_strobe for one cycle, with wr_addr = masked index.
REQ-017 A commit with addr < MEMORY_BYTES SHALL be dropped silently, with no wr_strobe.
REQ-018 On entry to READ, data_o SHALL load memory_output[(addr & (MEMORY_BYTES-1))*8 +: 8], and data_oe SHALL assert the same cycle data_o is valid.
REQ-019 READ SHALL hold data_o stable; on rd_s=1 it SHALL go to HOLD with a counter loaded to RDDLY_LEN.
REQ-020 HOLD SHALL keep data_oe=1 and decrement the counter each cycle; at 0 it SHALL deassert data_oe and go to IDLE.
REQ-021 rd_s=0 during HOLD SHALL re-enter READ with a fresh fetch, without dropping data_oe.
REQ-022 wr_s=0 during HOLD SHALL force data_oe=0 immediately and enter WRITE.
REQ-023 data_oe SHALL be 0 in IDLE, WRITE and BUSERR.

Reset
REQ-024 reset_n=0 SHALL asynchronously force: state IDLE, memory_input=0, data_o=0, data_oe=0, wr_strobe=0, wr_addr=0, hold counter=0, done_flag=0, synchronizers=1.
REQ-025 Reset mid-WRITE SHALL discard the pending commit, and reset mid-READ SHALL release the bus within the same cycle.

Configuration
REQ-026 With USB_STATUS_REG_EN defined: done_flag sets on crypto_done=1.
REQ-027 With USB_STATUS_REG_EN defined: a read at addr==STATUS_ADDR SHALL return {7'b0,done_flag} instead of memory_output.
REQ-028 With USB_STATUS_REG_EN defined: done_flag SHALL clear on HOLD->IDLE exit of that read; set wins over a simultaneous clear.
REQ-029 Without USB_STATUS_REG_EN, no done_flag SHALL exist, crypto_done SHALL be ignored, and STATUS_ADDR SHALL read memory_output normally.

Verification
REQ-030 Write: addr='h105, data_i='hA5, wr_n low 4 cycles then high -> memory_input[47:40]='hA5 and a single wr_strobe with wr_addr='h05, 3 cycles after wr_n rises.
REQ-031 Write low region: addr='h005 -> memory_input unchanged and no wr_strobe.
REQ-032 Read: memory_output byte 7='h3C, addr='h007, rd_n low 5 cycles -> data_o='h3C, with data_oe high until exactly RDDLY_LEN=3 cycles after rd_s rises.
REQ-033 Bus error: rd_n and wr_n low together -> no memory change and data_oe=0; the next normal write succeeds.
REQ-034 Status (macro on): crypto_done pulse; read STATUS_ADDR -> 'h01; second read -> 'h00; crypto_done on the clear cycle -> next read 'h01.
REQ-035 Reset asserted mid-write and mid-read -> all outputs at reset values, with no partial commit.

Source files
------------

// File: rtl/usb_reg_bridge.sv
// Bridges an asynchronous 8-bit strobe bus onto a byte-addressed region image with read hold-off.
// Define USB_STATUS_REG_EN to map a done-flag status register at STATUS_ADDR.
module usb_reg_bridge #(
    parameter int unsigned ADDR_WIDTH   = 21,
    parameter int unsigned MEMORY_WIDTH = 8,
    parameter int unsigned RDDLY_LEN    = 3,
    parameter int unsigned STATUS_ADDR  = 'h1FFFFF,
    localparam int unsigned MEMORY_BYTES = 1 << MEMORY_WIDTH
) (
    input  logic                      clk_usb,
    input  logic                      reset_n,
    input  logic [7:0]                data_i,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      rd_n,
    input  logic                      wr_n,
    output logic [7:0]                data_o,
    output logic                      data_oe,
    output logic [MEMORY_BYTES*8-1:0] memory_input,
    input  logic [MEMORY_BYTES*8-1:0] memory_output,
    output logic                      wr_strobe,
    output logic [MEMORY_WIDTH-1:0]   wr_addr,
    input  logic                      crypto_done
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StHold, StBusErr} state_e;

    state_e                    state_q, state_d;
    logic                      rd_meta_q, rd_s_q, wr_meta_q, wr_s_q;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [7:0]                wdata_q, wdata_d, rdata_q, rdata_d;
    logic [MEMORY_BYTES*8-1:0] mem_q, mem_d;
    logic                      oe_q, oe_d, strobe_q, strobe_d;
    logic [MEMORY_WIDTH-1:0]   waddr_q, waddr_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      capture, fetch, hold_exit;
    logic [MEMORY_WIDTH-1:0]   commit_idx, fetch_idx;

    assign commit_idx = addr_q[MEMORY_WIDTH-1:0];
    assign fetch_idx  = addr[MEMORY_WIDTH-1:0];

`ifdef USB_STATUS_REG_EN
    logic done_q, done_d, status_rd_q, status_rd_d;
`else
    logic unused_status;
    assign unused_status = ^{crypto_done, hold_exit, STATUS_ADDR};
`endif

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            rd_meta_q <= 1'b1;
            rd_s_q    <= 1'b1;
            wr_meta_q <= 1'b1;
            wr_s_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mem_q     <= '0;
            oe_q      <= 1'b0;
            strobe_q  <= 1'b0;
            waddr_q   <= '0;
            cnt_q     <= '0;
        end else begin
            rd_meta_q <= rd_n;
            rd_s_q    <= rd_meta_q;
            wr_meta_q <= wr_n;
            wr_s_q    <= wr_meta_q;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_q     <= mem_d;
            oe_q      <= oe_d;
            strobe_q  <= strobe_d;
            waddr_q   <= waddr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_d     = mem_q;
        rdata_d   = rdata_q;
        oe_d      = oe_q;
        strobe_d  = 1'b0;
        waddr_d   = waddr_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        fetch     = 1'b0;
        hold_exit = 1'b0;
        unique case (state_q)
            StIdle: begin
                oe_d = 1'b0;
                if (!rd_s_q && !wr_s_q) begin
                    state_d = StBusErr;
                end else if (!wr_s_q) begin
                    state_d = StWrite;
                    capture = 1'b1;
                end else if (!rd_s_q) begin
                    state_d = StRead;
                    fetch   = 1'b1;
                end
            end
            StWrite: begin
                if (wr_s_q) begin
                    state_d = StIdle;
                    // Low region is read-only from the bus side.
                    if (addr_q[ADDR_WIDTH-1:MEMORY_WIDTH] != '0) begin
                        mem_d[{commit_idx, 3'b000} +: 8] = wdata_q;
                        strobe_d = 1'b1;
                        waddr_d  = commit_idx;
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            StRead: begin
                if (rd_s_q) begin
                    state_d = StHold;
                    cnt_d   = RDDLY_LEN[3:0];
                end
            end
            StHold: begin
                if (!wr_s_q && !rd_s_q) begin
                    state_d = StBusErr;
                    oe_d    = 1'b0;
                end else if (!wr_s_q) begin
                    state_d = StWrite;
                    oe_d    = 1'b0;
                    capture = 1'b1;
                end else if (!rd_s_q) begin
                    state_d = StRead;
                    fetch   = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    state_d   = StIdle;
                    oe_d      = 1'b0;
                    cnt_d     = '0;
                    hold_exit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StBusErr: begin
                oe_d = 1'b0;
                if (rd_s_q && wr_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (capture) begin
            addr_d  = addr;
            wdata_d = data_i;
        end
        if (fetch) begin
            oe_d    = 1'b1;
            rdata_d = memory_output[{fetch_idx, 3'b000} +: 8];
        end
`ifdef USB_STATUS_REG_EN
        status_rd_d = status_rd_q;
        done_d      = done_q;
        if (fetch) begin
            status_rd_d = (addr == STATUS_ADDR[ADDR_WIDTH-1:0]);
            if (status_rd_d) begin
                rdata_d = {7'b0, done_q};
            end
        end
        if (hold_exit && status_rd_q) begin
            done_d = 1'b0;
        end
        if (crypto_done) begin
            done_d = 1'b1;
        end
`endif
    end

`ifdef USB_STATUS_REG_EN
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            done_q      <= 1'b0;
            status_rd_q <= 1'b0;
        end else begin
            done_q      <= done_d;
            status_rd_q <= status_rd_d;
        end
    end
`endif

    assign data_o       = rdata_q;
    assign data_oe      = oe_q;
    assign memory_input = mem_q;
    assign wr_strobe    = strobe_q;
    assign wr_addr      = waddr_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Self-checking bench for usb_reg_bridge: directed vector table, hand-built corner sequences
// and randomized transactions against a byte-array reference model.
module tb_usb_reg_bridge;

    localparam int RDDLY = 3;
    localparam logic [20:0] STATUS = 21'h1FFFFF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    data_i;
    logic [20:0]   addr;
    logic          rd_n, wr_n;
    logic [7:0]    data_o;
    logic          data_oe;
    logic [2047:0] mem_in, mem_out;
    logic          wr_strobe;
    logic [7:0]    wr_addr;
    logic          crypto_done;

    logic [7:0] mdl [256];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_wr;
        logic [20:0] a;
        logic [7:0]  d;
        int          low;
        bit          exp_pulse;
        logic [7:0]  exp_val;
    } vec_t;
    vec_t vecs [8];

    usb_reg_bridge dut (
        .clk_usb       (clk),
        .reset_n       (reset_n),
        .data_i        (data_i),
        .addr          (addr),
        .rd_n          (rd_n),
        .wr_n          (wr_n),
        .data_o        (data_o),
        .data_oe       (data_oe),
        .memory_input  (mem_in),
        .memory_output (mem_out),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .crypto_done   (crypto_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string name);
        int nbad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_in[i*8 +: 8] !== mdl[i]) nbad++;
        end
        check(name, nbad, 0);
    endtask

    // Commit appears on the third edge after wr_n rises (two sync flops plus the commit edge).
    task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int low,
                            input bit exp_pulse, input logic [7:0] exp_wa);
        int pulses = 0;
        int first = 0;
        logic [7:0] wa = 8'h00;
        bit oe_seen = 1'b0;
        addr = a;
        data_i = d;
        wr_n = 1'b0;
        repeat (low) begin
            tick();
            if (data_oe) oe_seen = 1'b1;
        end
        wr_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (data_oe) oe_seen = 1'b1;
            if (wr_strobe) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    wa = wr_addr;
                end
            end
        end
        check("wr_strobe_count", pulses, {31'd0, exp_pulse});
        if (exp_pulse) begin
            check("wr_strobe_latency", first, 3);
            check("wr_addr", wa, exp_wa);
        end
        check("wr_data_oe", oe_seen, 0);
    endtask

    // After rd_n rises the bus stays driven for two sync cycles, the READ exit edge,
    // and RDDLY_LEN-1 further hold cycles: 2 + RDDLY_LEN samples in total.
    task automatic do_read(input logic [20:0] a, input int low, input logic [7:0] exp_d,
                           input bit done_pulse);
        int high = 0;
        bit done = 1'b0;
        addr = a;
        rd_n = 1'b0;
        repeat (low) tick();
        check("rd_data_oe", data_oe, 1);
        check("rd_data", data_o, exp_d);
        rd_n = 1'b1;
        if (done_pulse) crypto_done = 1'b1;
        while (!done && high < 30) begin
            tick();
            if (!data_oe) done = 1'b1;
            else high++;
        end
        crypto_done = 1'b0;
        check("rd_release_len", high, 2 + RDDLY);
    endtask

    initial begin
        logic [20:0] a;
        logic [7:0]  d;
        bit          oe_drop, bad;

        vecs[0] = '{1'b1, 21'h000105, 8'hA5, 4, 1'b1, 8'h05};
        vecs[1] = '{1'b1, 21'h000005, 8'h5A, 4, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 21'h1FFFFE, 8'h77, 3, 1'b1, 8'hFE};
        vecs[3] = '{1'b1, 21'h0000FF, 8'h11, 5, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 21'h000100, 8'h22, 2, 1'b1, 8'h00};
        vecs[5] = '{1'b0, 21'h000007, 8'h3C, 5, 1'b0, 8'h3C};
        vecs[6] = '{1'b0, 21'h0ABCFE, 8'hC3, 3, 1'b0, 8'hC3};
        vecs[7] = '{1'b0, 21'h000000, 8'h81, 4, 1'b0, 8'h81};

        for (int i = 0; i < 256; i++) begin
            mdl[i] = 8'h00;
            mem_out[i*8 +: 8] = 8'($urandom);
        end
        reset_n = 1'b0;
        rd_n = 1'b1;
        wr_n = 1'b1;
        addr = '0;
        data_i = '0;
        crypto_done = 1'b0;
        repeat (3) tick();
        check("rst_data_oe", data_oe, 0);
        check("rst_data_o", data_o, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check_mem("rst_mem_image");
        reset_n = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].a, vecs[i].d, vecs[i].low, vecs[i].exp_pulse, vecs[i].exp_val);
                if (vecs[i].a >= 256) mdl[vecs[i].a % 256] = vecs[i].d;
                check_mem("vec_mem_image");
            end else begin
                mem_out[(vecs[i].a % 256) * 8 +: 8] = vecs[i].d;
                do_read(vecs[i].a, vecs[i].low, vecs[i].exp_val, 1'b0);
            end
        end

        // Read holds data while memory changes, then re-fetches from HOLD without dropping oe.
        mem_out[16*8 +: 8] = 8'h44;
        mem_out[32*8 +: 8] = 8'h66;
        addr = 21'h010;
        rd_n = 1'b0;
        repeat (4) tick();
        check("reent_first", data_o, 8'h44);
        mem_out[16*8 +: 8] = 8'h55;
        tick();
        check("rd_stable", data_o, 8'h44);
        rd_n = 1'b1;
        repeat (2) tick();
        addr = 21'h020;
        rd_n = 1'b0;
        oe_drop = 1'b0;
        repeat (6) begin
            tick();
            if (!data_oe) oe_drop = 1'b1;
        end
        check("reent_oe_kept", oe_drop, 0);
        check("reent_data", data_o, 8'h66);
        rd_n = 1'b1;
        for (int k = 0; k < 30 && data_oe; k++) tick();
        check("reent_release", data_oe, 0);

        // Write during HOLD cuts the bus one cycle before the hold count would.
        addr = 21'h011;
        rd_n = 1'b0;
        repeat (4) tick();
        rd_n = 1'b1;
        repeat (2) tick();
        addr = 21'h130;
        data_i = 8'h99;
        wr_n = 1'b0;
        repeat (2) tick();
        check("hold_wr_oe_before", data_oe, 1);
        tick();
        check("hold_wr_oe_forced", data_oe, 0);
        do_write(21'h130, 8'h99, 2, 1'b1, 8'h30);
        mdl[8'h30] = 8'h99;
        check_mem("hold_wr_mem_image");

        // Bus error: both strobes low together.
        addr = 21'h140;
        data_i = 8'hEE;
        rd_n = 1'b0;
        wr_n = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (data_oe || wr_strobe) bad = 1'b1;
        end
        rd_n = 1'b1;
        wr_n = 1'b1;
        repeat (8) begin
            tick();
            if (data_oe || wr_strobe) bad = 1'b1;
        end
        check("buserr_quiet", bad, 0);
        check_mem("buserr_mem_image");
        do_write(21'h141, 8'h42, 4, 1'b1, 8'h41);
        mdl[8'h41] = 8'h42;
        check_mem("post_buserr_mem_image");

`ifdef USB_STATUS_REG_EN
        crypto_done = 1'b1;
        tick();
        crypto_done = 1'b0;
        do_read(STATUS, 4, 8'h01, 1'b0);
        do_read(STATUS, 4, 8'h00, 1'b1);
        do_read(STATUS, 4, 8'h01, 1'b0);
`else
        mem_out[255*8 +: 8] = 8'hB7;
        crypto_done = 1'b1;
        tick();
        crypto_done = 1'b0;
        do_read(STATUS, 4, 8'hB7, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 1) ? 21'($urandom) : 21'($urandom_range(0, 255));
            if (a == STATUS) a = 21'h1FFFFE;
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, $urandom_range(2, 6), a >= 256, 8'(a % 256));
                if (a >= 256) mdl[a % 256] = d;
                check_mem("rand_mem_image");
            end else begin
                if ($urandom_range(0, 3) == 0) mem_out[(a % 256) * 8 +: 8] = d;
                do_read(a, $urandom_range(3, 6), mem_out[(a % 256) * 8 +: 8], 1'b0);
            end
        end

        // Reset during a write: nothing commits, image and outputs clear at once.
        addr = 21'h1AB;
        data_i = 8'h5D;
        wr_n = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        check("rstw_data_oe", data_oe, 0);
        check("rstw_wr_strobe", wr_strobe, 0);
        check("rstw_wr_addr", wr_addr, 0);
        check_mem("rstw_mem_image");
        wr_n = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            tick();
            if (wr_strobe) bad = 1'b1;
        end
        check("rstw_no_commit", bad, 0);
        check_mem("rstw_mem_after");

        // Reset during a read releases the bus without waiting for a clock edge.
        mem_out[8'h33*8 +: 8] = 8'h7E;
        addr = 21'h033;
        rd_n = 1'b0;
        repeat (4) tick();
        check("rstr_oe_before", data_oe, 1);
        reset_n = 1'b0;
        #1;
        check("rstr_data_oe", data_oe, 0);
        check("rstr_data_o", data_o, 0);
        rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (data_oe) bad = 1'b1;
        end
        check("rstr_quiet", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
